// File: rtl/oscillator.sv
// oscillator: period counter over a programmable divider with an incrementally
//   computed 8-bit phase floor(count*256/divider), no divider circuit.
// Latency: all outputs registered, one edge from inputs; backpressure: none,
//   `en` low freezes state; divider changes are deferred to the period boundary.
//
// Ports:
//   clk, n_rst            - clock (rising edge), async active-low reset
//   en                    - advance enable
//   phase_rst             - synchronous phase restart (applies pending divider)
//   div_load, divider_in  - divider load strobe and requested value
//   divider, count        - active divider and period counter (0..divider-1)
//   scaled_sig            - phase scaled to 8 bits
//   period_start          - one-cycle pulse while count reads 0 after a wrap
module oscillator (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic        phase_rst,
  input  logic        div_load,
  input  logic [17:0] divider_in,
  output logic [17:0] divider,
  output logic [17:0] count,
  output logic [7:0]  scaled_sig,
  output logic        period_start
);

  logic [17:0] divider_q, divider_d;
  logic [17:0] count_q, count_d;
  logic [7:0]  sig_q, sig_d;
  logic        ps_q, ps_d;
  logic [18:0] acc_q, acc_d;
  logic [17:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;

  logic [17:0] div_legal;
  logic        silent;
  logic        wrap;
  logic        apply;
  logic [18:0] acc_t;

  // Dividers below 256 are raised to 256 so the phase advances at most once
  // per tick; 0 means silent.
  always_comb begin
    div_legal = divider_in;
    if (divider_in == 18'd0) begin
      div_legal = 18'd0;
    end else if (divider_in < 18'd256) begin
      div_legal = 18'd256;
    end
  end

  assign silent = (divider_q == 18'd0);
  assign wrap   = en && !phase_rst && !silent && (count_q == divider_q - 18'd1);
  assign apply  = silent || wrap || phase_rst;
  // acc < divider < 2^18, so acc+256 always fits in 19 bits.
  assign acc_t  = acc_q + 19'd256;

  always_comb begin
    divider_d  = divider_q;
    count_d    = count_q;
    sig_d      = sig_q;
    ps_d       = 1'b0;
    acc_d      = acc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    // Divider update: a load coinciding with an apply point bypasses pending.
    if (apply) begin
      pend_vld_d = 1'b0;
      if (div_load) begin
        divider_d = div_legal;
      end else if (pend_vld_q) begin
        divider_d = pend_q;
      end
    end else if (div_load) begin
      pend_d     = div_legal;
      pend_vld_d = 1'b1;
    end

    // Phase datapath: acc tracks count*256 mod divider, so each carry out of
    // the modular add is exactly one step of floor(count*256/divider).
    if (phase_rst || silent || wrap) begin
      count_d = 18'd0;
      acc_d   = 19'd0;
      sig_d   = 8'd0;
      ps_d    = wrap;
    end else if (en) begin
      count_d = count_q + 18'd1;
      if (acc_t >= {1'b0, divider_q}) begin
        acc_d = acc_t - {1'b0, divider_q};
        sig_d = sig_q + 8'd1;
      end else begin
        acc_d = acc_t;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      divider_q  <= 18'd0;
      count_q    <= 18'd0;
      sig_q      <= 8'd0;
      ps_q       <= 1'b0;
      acc_q      <= 19'd0;
      pend_q     <= 18'd0;
      pend_vld_q <= 1'b0;
    end else begin
      divider_q  <= divider_d;
      count_q    <= count_d;
      sig_q      <= sig_d;
      ps_q       <= ps_d;
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign divider      = divider_q;
  assign count        = count_q;
  assign scaled_sig   = sig_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_oscillator.sv
// tb_oscillator: directed stimulus for the oscillator phase generator.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: none; the run is bounded by a global watchdog.
module tb_oscillator;

  logic        clk;
  logic        n_rst;
  logic        en;
  logic        phase_rst;
  logic        div_load;
  logic [17:0] divider_in;
  logic [17:0] divider;
  logic [17:0] count;
  logic [7:0]  scaled_sig;
  logic        period_start;

  int n_chk;
  int n_pass;

  oscillator dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .en           (en),
    .phase_rst    (phase_rst),
    .div_load     (div_load),
    .divider_in   (divider_in),
    .divider      (divider),
    .count        (count),
    .scaled_sig   (scaled_sig),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected phase is computed directly from the definition floor(c*256/d).
  task automatic chk_cyc(input string tag, input int c, input int d, input bit ps_want);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".sig"}, 32'(scaled_sig), 32'((c * 256) / d));
    chk({tag, ".ps"}, 32'(period_start), 32'(ps_want));
  endtask

  // Restart with a new divider in one edge (load coinciding with phase_rst).
  task automatic restart_with(input logic [17:0] d);
    phase_rst  = 1'b1;
    div_load   = 1'b1;
    divider_in = d;
    tick();
    phase_rst  = 1'b0;
    div_load   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    n_rst      = 1'b0;
    en         = 1'b0;
    phase_rst  = 1'b0;
    div_load   = 1'b0;
    divider_in = 18'd0;
    repeat (2) tick();

    // Reset state
    chk("rst.divider", 32'(divider), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.sig", 32'(scaled_sig), 32'd0);
    chk("rst.ps", 32'(period_start), 32'd0);
    n_rst = 1'b1;
    tick();
    chk("idle.count", 32'(count), 32'd0);

    // Load 512 from silent with en=1: two periods
    en         = 1'b1;
    div_load   = 1'b1;
    divider_in = 18'd512;
    tick();
    div_load = 1'b0;
    chk("d512.divider", 32'(divider), 32'd512);
    for (int i = 0; i < 1024; i++) begin
      chk_cyc("d512", i % 512, 512, (i > 0) && (i % 512 == 0));
      if (i == 511) chk("d512.sig@511", 32'(scaled_sig), 32'd255);
      tick();
    end

    // Divider 300: three periods
    restart_with(18'd300);
    chk("d300.divider", 32'(divider), 32'd300);
    for (int i = 0; i < 900; i++) begin
      chk_cyc("d300", i % 300, 300, (i > 0) && (i % 300 == 0));
      if (i % 300 == 299) chk("d300.sig@299", 32'(scaled_sig), 32'd255);
      tick();
    end

    // Pending load deferred to the wrap
    restart_with(18'd512);
    repeat (100) tick();
    chk("pend.count100", 32'(count), 32'd100);
    div_load   = 1'b1;
    divider_in = 18'd1024;
    tick();
    div_load = 1'b0;
    chk("pend.div_held", 32'(divider), 32'd512);
    repeat (410) tick();
    chk("pend.count511", 32'(count), 32'd511);
    chk("pend.div511", 32'(divider), 32'd512);
    tick();
    chk("pend.count_wrap", 32'(count), 32'd0);
    chk("pend.div_new", 32'(divider), 32'd1024);
    chk("pend.ps_wrap", 32'(period_start), 32'd1);

    // Last load wins
    div_load   = 1'b1;
    divider_in = 18'd2048;
    tick();
    divider_in = 18'd4096;
    tick();
    div_load = 1'b0;
    repeat (1021) tick();
    chk("lw.count1023", 32'(count), 32'd1023);
    chk("lw.div_held", 32'(divider), 32'd1024);
    tick();
    chk("lw.div_new", 32'(divider), 32'd4096);
    chk("lw.count_wrap", 32'(count), 32'd0);

    // Legalisation: 100 -> 256, phase equals count
    restart_with(18'd100);
    chk("leg.divider", 32'(divider), 32'd256);
    for (int i = 0; i < 300; i++) begin
      chk("leg.sig_eq_count", 32'(scaled_sig), 32'(i % 256));
      chk("leg.count", 32'(count), 32'(i % 256));
      tick();
    end

    // Load 0: silent
    restart_with(18'd0);
    for (int i = 0; i < 50; i++) begin
      chk("sil.divider", 32'(divider), 32'd0);
      chk_cyc("sil", 0, 1, 1'b0);
      tick();
    end

    // Load from silent, then freeze and restart
    div_load   = 1'b1;
    divider_in = 18'd512;
    tick();
    div_load = 1'b0;
    chk("ls.divider", 32'(divider), 32'd512);
    chk("ls.count", 32'(count), 32'd0);
    chk("ls.ps", 32'(period_start), 32'd0);
    repeat (37) tick();
    chk("frz.count37", 32'(count), 32'd37);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cyc("frz", 37, 512, 1'b0);
      chk("frz.divider", 32'(divider), 32'd512);
    end
    en = 1'b1;
    tick();
    chk_cyc("en_resume", 38, 512, 1'b0);
    repeat (162) tick();
    chk("prst.count200", 32'(count), 32'd200);
    phase_rst = 1'b1;
    tick();
    phase_rst = 1'b0;
    chk_cyc("prst", 0, 512, 1'b0);
    chk("prst.divider", 32'(divider), 32'd512);

    // Asynchronous reset mid-period
    repeat (400) tick();
    chk("arst.count400", 32'(count), 32'd400);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst.divider", 32'(divider), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.sig", 32'(scaled_sig), 32'd0);
    chk("arst.ps", 32'(period_start), 32'd0);
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post.count", 32'(count), 32'd0);
      chk("post.divider", 32'(divider), 32'd0);
    end
    div_load   = 1'b1;
    divider_in = 18'd256;
    tick();
    div_load = 1'b0;
    chk("reload.divider", 32'(divider), 32'd256);
    tick();
    chk_cyc("reload", 1, 256, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
